mux_tree_pipe: RTL
==================

// Module: mux_tree_pipe
// PURPOSE
//  Parametrised, pipelined N:1 multiplexer built as a binary tree of 2:1 stages.
//  There is one register rank per tree level, and valid/ready handshakes on both sides.
//  It replaces the fixed combinational 8:1 tree in wide datapaths that need
//  registered timing and backpressure.
//  It also has a SCAN mode: an internal pointer supplies the select and steps
//  round-robin through every channel.
// PARAMETERS
//  WIDTH     8   data bits per channel
//  SEL_BITS  3   select width; N = 2**SEL_BITS channels (SEL_BITS >= 1)
// PORTS
//  clk        in   1             single clock, rising edge
//  rst        in   1             asynchronous reset, active-high
//  din        in   N*WIDTH       flattened channels; channel k = din[k*WIDTH +: WIDTH]
//  sel        in   SEL_BITS      channel select, used when scan_en=0
//  scan_en    in   1             1: select comes from scan_ptr
//  in_valid   in   1             din/sel/scan_en are valid this cycle
//  in_ready   out  1             block can accept this cycle
//  dout       out  WIDTH         selected channel data
//  out_sel    out  SEL_BITS      effective select that produced dout
//  out_valid  out  1             dout/out_sel are valid
//  out_ready  in   1             downstream accepts this cycle
//  scan_ptr   out  SEL_BITS      next select used in SCAN mode
// BEHAVIOUR
//  - Reset (async, rst=1): all stage valids clear, and dout=0, out_sel=0, out_valid=0, scan_ptr=0.
//    All in-flight data is discarded. No output is produced from pre-reset inputs.
//  - Accept: an input is accepted when in_valid && in_ready at a clk edge.
//  - Effective select: esel = scan_en ? scan_ptr : sel.
//    esel is sampled at the same edge as din.
//  - Tree ordering:
//    - Level 0 pairs adjacent channels (2j, 2j+1) using esel[0].
//    - Level L uses esel[L].
//    - Final result is dout = channel[esel].
//  - Pipeline: stages 0..SEL_BITS-1.
//    - Stage L registers the outputs of level L, its valid bit, and esel, which is carried to out_sel.
//    - The last stage drives dout, out_sel and out_valid directly from registers.
//    - There is no combinational path from din to dout.
//  - Latency: SEL_BITS cycles from accept to out_valid, with no stall.
//  - Throughput: 1 per cycle.
//  - Flow control (bubble-collapsing):
//    - Stage L loads when it is empty or its contents advance this cycle.
//    - The last stage advances when out_ready=1.
//    - in_ready = !valid[0] || stage 0 advances. It is combinational from out_ready and the stage valids only.
//  - Stall: while out_valid && !out_ready, dout and out_sel are held stable.
//    - Up to SEL_BITS items are held with no loss, duplication or reordering.
//    - Once every stage is full, in_ready=0.
//  - Scan pointer:
//    - On each accept with scan_en=1, scan_ptr increments modulo N (N-1 -> 0).
//    - With scan_en=0, scan_ptr holds.
//    - Toggling scan_en affects only later accepts; in-flight items keep their select.
//  - Simultaneous events:
//    - An accept and an output handshake in the same cycle on a full pipe are both honoured; occupancy is unchanged.
//    - rst overrides everything.
//  - Arithmetic: no arithmetic beyond the modulo-N pointer increment. dout is exactly the selected WIDTH bits.
// TESTING
//  1. WIDTH=8, SEL_BITS=3, channel k = 8'h10+k, sel=5, one accept
//     -> dout=8'h15, out_sel=5, out_valid=1 exactly 3 cycles later, for 1 cycle.
//  2. Stream sel=0..7 back-to-back, out_ready=1
//     -> dout=8'h10..8'h17 on 8 consecutive cycles; in_ready stays 1.
//  3. out_ready=0 for 6 cycles while streaming
//     -> 3 accepts, then in_ready=0 with dout held.
//     After release: all items exit in order, none lost or duplicated.
//  4. scan_en=1, 10 accepts
//     -> out_sel 0,1,...,7,0,1; scan_ptr=2 afterwards.
//     Then scan_en=0 with sel=6 -> out_sel=6 and scan_ptr stays 2.
//  5. Assert rst asynchronously with 2 items in flight
//     -> out_valid=0 and scan_ptr=0 immediately, before the next edge.
//     After release, no stale output appears.
//  6. SEL_BITS=1, WIDTH=1, din=2'b10, sel=1
//     -> dout=1 one cycle after accept (registered 2:1).

Source files
------------

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer tree with valid/ready flow control on both sides.
// Each tree level has its own register rank. Each stage carries the effective
// select that its item was accepted with, so a later change of sel or scan_en
// never disturbs items that are already in the pipe. A SCAN mode replaces the
// external select with an internal round-robin pointer.
module mux_tree_pipe #(
    parameter int WIDTH    = 8,
    parameter int SEL_BITS = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [(2**SEL_BITS)*WIDTH-1:0]   din,
    input  logic [SEL_BITS-1:0]              sel,
    input  logic                             scan_en,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [WIDTH-1:0]                 dout,
    output logic [SEL_BITS-1:0]              out_sel,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SEL_BITS-1:0]              scan_ptr
);

    localparam int N    = 2 ** SEL_BITS;
    localparam int HALF = N / 2;

    // Stage l holds N >> (l+1) live entries. Unused upper entries stay at zero.
    logic [WIDTH-1:0]    data_r     [SEL_BITS][HALF];
    logic [WIDTH-1:0]    data_nxt_s [SEL_BITS][HALF];
    logic [SEL_BITS-1:0] sel_r      [SEL_BITS];
    logic [SEL_BITS-1:0] sel_prev_s [SEL_BITS];
    logic [SEL_BITS-1:0] valid_r;
    logic [SEL_BITS-1:0] valid_prev_s;
    // ld_s[l] : stage l may capture this cycle.
    // ld_s[SEL_BITS] is the downstream acceptance.
    logic [SEL_BITS:0]   ld_s;
    logic [SEL_BITS-1:0] esel_s;

    assign esel_s = scan_en ? scan_ptr : sel;

    // Mux network. Level 0 picks within adjacent input pairs. Level l picks
    // within adjacent pairs of stage l-1 using the select bit that stage carries.
    genvar gl, gj;
    for (gl = 0; gl < SEL_BITS; gl++) begin : g_level
        localparam int CNT = N >> (gl + 1);
        for (gj = 0; gj < HALF; gj++) begin : g_entry
            if (gj < CNT) begin : g_live
                if (gl == 0) begin : g_first
                    assign data_nxt_s[gl][gj] = esel_s[0]
                        ? din[(2*gj+1)*WIDTH +: WIDTH]
                        : din[(2*gj)*WIDTH +: WIDTH];
                end else begin : g_inner
                    assign data_nxt_s[gl][gj] = sel_r[gl-1][gl]
                        ? data_r[gl-1][2*gj+1]
                        : data_r[gl-1][2*gj];
                end
            end else begin : g_dead
                assign data_nxt_s[gl][gj] = '0;
            end
        end
    end

    // Per-stage upstream valid/select. Stage 0 is fed from the input port.
    always_comb begin
        valid_prev_s    = '0;
        valid_prev_s[0] = in_valid;
        for (int l = 0; l < SEL_BITS; l++) begin
            sel_prev_s[l] = '0;
        end
        sel_prev_s[0] = esel_s;
        for (int l = 1; l < SEL_BITS; l++) begin
            valid_prev_s[l] = valid_r[l-1];
            sel_prev_s[l]   = sel_r[l-1];
        end
    end

    // Bubble-collapsing load enables, computed from the output end backwards.
    // A stage loads when it is empty or its item moves on this cycle.
    always_comb begin
        ld_s           = '0;
        ld_s[SEL_BITS] = out_ready;
        for (int l = SEL_BITS - 1; l >= 0; l--) begin
            ld_s[l] = !valid_r[l] || ld_s[l+1];
        end
    end

    // Stage registers and the scan pointer.
    // Reset clears everything so that no pre-reset data can emerge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r  <= '0;
            scan_ptr <= '0;
            for (int l = 0; l < SEL_BITS; l++) begin
                sel_r[l] <= '0;
                for (int j = 0; j < HALF; j++) begin
                    data_r[l][j] <= '0;
                end
            end
        end else begin
            if (in_valid && ld_s[0] && scan_en) begin
                scan_ptr <= scan_ptr + SEL_BITS'(1);
            end
            for (int l = 0; l < SEL_BITS; l++) begin
                if (ld_s[l]) begin
                    valid_r[l] <= valid_prev_s[l];
                    sel_r[l]   <= sel_prev_s[l];
                    for (int j = 0; j < HALF; j++) begin
                        data_r[l][j] <= data_nxt_s[l][j];
                    end
                end
            end
        end
    end

    assign in_ready  = ld_s[0];
    assign dout      = data_r[SEL_BITS-1][0];
    assign out_sel   = sel_r[SEL_BITS-1];
    assign out_valid = valid_r[SEL_BITS-1];

endmodule
